// File: rtl/fifo_read_streamer_pkg.sv
// Shared FIFO definitions: default word width, word type and skid depth.
package fifo_read_streamer_pkg;

  localparam int unsigned FIFO_DATA_WIDTH = 16;
  localparam int unsigned SKID_DEPTH      = 2;

  typedef logic [FIFO_DATA_WIDTH-1:0] fifo_word_t;

endpackage

// File: rtl/fifo_read_streamer_skid_buf2.sv
// Two-entry circular skid buffer; head entry is always presented on head_data.
module fifo_skid_buf2
  import fifo_read_streamer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic [1:0]            occ_q, occ_d;
  logic [2:0]            occ_sum;

  always_comb begin
    occ_sum = {1'b0, occ_q} + {2'b00, push} - {2'b00, pop};
    occ_d   = occ_sum[1:0];
    head_d  = head_q ^ pop;
    tail_d  = tail_q ^ push;
    if (flush) begin
      occ_d  = 2'd0;
      head_d = 1'b0;
      tail_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= 2'd0;
      head_q <= 1'b0;
      tail_q <= 1'b0;
      for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
      if (push && !flush) begin
        mem_q[tail_q] <= push_data;
      end
    end
  end

  assign occ       = occ_q;
  assign head_data = mem_q[head_q];

  // The upstream credit rule must keep the buffer from overrunning or underrunning.
  assert property (@(posedge clk) disable iff (!rst_n) occ_sum <= 3'd2);
  assert property (@(posedge clk) disable iff (!rst_n) pop |-> (occ_q != 2'd0));

endmodule

// File: rtl/fifo_read_streamer.sv
// Pops words from a synchronous FIFO and streams them out on valid/ready at full rate,
// absorbing the FIFO's one-cycle read latency in a 2-entry skid buffer.
module fifo_read_streamer
  import fifo_read_streamer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  flush,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_W-1:0]      popped_cnt,
  output logic                  underflow_err
);

  logic             inflight_q;
  logic             pop;
  logic             capture;
  logic [1:0]       occ;
  logic [2:0]       credit;
  logic [CNT_W-1:0] popped_cnt_q, popped_cnt_d;
  logic             underflow_err_q, underflow_err_d;

  always_comb begin
    m_valid = (occ != 2'd0);
    pop     = m_valid && m_ready;
    capture = inflight_q && !flush;
    // Words that will occupy the buffer next cycle; a new read needs a free slot for it.
    credit  = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rd_en = rst_n && enable && !flush && !fifo_empty && (credit <= 3'd1);

    popped_cnt_d    = popped_cnt_q;
    if (pop) begin
      popped_cnt_d = popped_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    underflow_err_d = underflow_err_q || (fifo_underflow && inflight_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q      <= 1'b0;
      popped_cnt_q    <= '0;
      underflow_err_q <= 1'b0;
    end else begin
      inflight_q      <= fifo_rd_en;
      popped_cnt_q    <= popped_cnt_d;
      underflow_err_q <= underflow_err_d;
    end
  end

  fifo_skid_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push     (capture),
    .push_data(fifo_data_out),
    .pop      (pop),
    .occ      (occ),
    .head_data(m_data)
  );

  assign popped_cnt    = popped_cnt_q;
  assign underflow_err = underflow_err_q;

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Bench for fifo_read_streamer: queue-based FIFO model upstream, scoreboard downstream.
module tb_fifo_read_streamer;

  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic          m_ready = 1'b0;
  logic          uf_force = 1'b0;
  logic          fifo_rd_en, fifo_empty, fifo_underflow, m_valid, underflow_err;
  logic [DW-1:0] fifo_data_out, m_data;
  logic [CW-1:0] popped_cnt;
  logic          uf_model;
  int            fifo_cnt = 0;
  logic [DW-1:0] mem[$];
  logic [DW-1:0] wr_q[$];
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  fifo_read_streamer #(
    .DATA_WIDTH(DW),
    .CNT_W     (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .flush         (flush),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_data_out (fifo_data_out),
    .fifo_empty    (fifo_empty),
    .fifo_underflow(fifo_underflow),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .popped_cnt    (popped_cnt),
    .underflow_err (underflow_err)
  );

  // Behavioural synchronous FIFO: registered read data and underflow flag.
  assign fifo_empty     = (fifo_cnt == 0);
  assign fifo_underflow = uf_model | uf_force;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem.delete();
      fifo_data_out <= '0;
      uf_model      <= 1'b0;
      fifo_cnt      <= 0;
    end else begin
      uf_model <= 1'b0;
      if (fifo_rd_en) begin
        if (mem.size() > 0) fifo_data_out <= mem.pop_front();
        else uf_model <= 1'b1;
      end
      while (wr_q.size() > 0) mem.push_back(wr_q.pop_front());
      fifo_cnt <= mem.size();
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; m_ready = 1'b0; uf_force = 1'b0;
    wr_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wr_q.delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total += 5;
    if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
    if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    if (m_data !== '0) begin bad++; $display("FAIL reset_m_data: got %h want 0", m_data); end
    if (popped_cnt !== '0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", popped_cnt); end
    if (underflow_err !== 1'b0) begin bad++; $display("FAIL reset_uf_err: got %b want 0", underflow_err); end
    do_reset();
  endtask

  task automatic test_stream();
    int fall, first, last, got;
    logic [DW-1:0] exp;
    fall = -1; first = -1; last = -1; got = 0;
    do_reset();
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 8; i++) wr_q.push_back(16'hA001 + 16'(i));
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); #1;
      if (fall < 0 && !fifo_empty) fall = c;
      if (m_valid && m_ready) begin
        exp = 16'hA001 + 16'(got);
        total++;
        if (m_data !== exp) begin bad++; $display("FAIL stream_data: got %h want %h", m_data, exp); end
        if (first < 0) first = c;
        last = c;
        got++;
      end
    end
    total += 5;
    if (got != 8) begin bad++; $display("FAIL stream_count: got %0d want 8", got); end
    if (first != fall + 2) begin bad++; $display("FAIL stream_latency: got %0d want %0d", first - fall, 2); end
    if (last - first != 7) begin bad++; $display("FAIL stream_gapless: got span %0d want 7", last - first); end
    if (popped_cnt !== 4'd8) begin bad++; $display("FAIL stream_cnt: got %0d want 8", popped_cnt); end
    if (underflow_err !== 1'b0) begin bad++; $display("FAIL stream_uf_err: got %b want 0", underflow_err); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w[5];
    int rd, got, first, last;
    rd = 0; got = 0; first = -1; last = -1;
    do_reset();
    enable = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin w[i] = 16'($urandom); wr_q.push_back(w[i]); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (fifo_rd_en) rd++;
    end
    total += 3;
    if (rd != 2) begin bad++; $display("FAIL bp_rd_pulses: got %0d want 2", rd); end
    if (m_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", m_valid); end
    if (m_data !== w[0]) begin bad++; $display("FAIL bp_head: got %h want %h", m_data, w[0]); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      m_ready = 1'b1;
      #1;
      if (m_valid && m_ready) begin
        total++;
        if (got >= 5) begin bad++; $display("FAIL bp_extra: got word %h want none", m_data); end
        else if (m_data !== w[got]) begin
          bad++; $display("FAIL bp_data: got %h want %h", m_data, w[got]);
        end
        if (first < 0) first = c;
        last = c;
        got++;
      end
    end
    total += 3;
    if (got != 5) begin bad++; $display("FAIL bp_count: got %0d want 5", got); end
    if (last - first != 4) begin bad++; $display("FAIL bp_gapless: got span %0d want 4", last - first); end
    if (popped_cnt !== 4'd5) begin bad++; $display("FAIL bp_cnt: got %0d want 5", popped_cnt); end
  endtask

  task automatic test_single();
    int rd, got, uf;
    rd = 0; got = 0; uf = 0;
    do_reset();
    enable = 1'b1; m_ready = 1'b1;
    wr_q.push_back(16'h1234);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); #1;
      if (fifo_rd_en) rd++;
      if (fifo_underflow) uf++;
      if (m_valid && m_ready) begin
        total++;
        if (m_data !== 16'h1234) begin bad++; $display("FAIL single_data: got %h want 1234", m_data); end
        got++;
      end
    end
    total += 4;
    if (rd != 1) begin bad++; $display("FAIL single_rd: got %0d want 1", rd); end
    if (got != 1) begin bad++; $display("FAIL single_count: got %0d want 1", got); end
    if (uf != 0) begin bad++; $display("FAIL single_fifo_uf: got %0d want 0", uf); end
    if (underflow_err !== 1'b0) begin bad++; $display("FAIL single_uf_err: got %b want 0", underflow_err); end
  endtask

  task automatic test_flush();
    logic [DW-1:0] exp[$];
    logic [DW-1:0] w;
    int got;
    bit done, prev_flush;
    got = 0; done = 0; prev_flush = 0;
    do_reset();
    enable = 1'b1; m_ready = 1'b1;
    // Streaming steadily, the word in flight during the flush is the 4th one; it is lost.
    for (int i = 0; i < 10; i++) begin
      w = 16'($urandom);
      wr_q.push_back(w);
      if (i != 3) exp.push_back(w);
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      flush = (got == 2) && !done;
      if (flush) done = 1;
      #1;
      if (flush) begin
        total++;
        if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL flush_rd_en: got %b want 0", fifo_rd_en); end
      end
      if (prev_flush) begin
        total++;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", m_valid); end
      end
      if (m_valid && m_ready) begin
        total++;
        if (exp.size() == 0) begin bad++; $display("FAIL flush_extra: got %h want none", m_data); end
        else begin
          w = exp.pop_front();
          if (m_data !== w) begin bad++; $display("FAIL flush_data: got %h want %h", m_data, w); end
        end
        got++;
      end
      prev_flush = flush;
    end
    flush = 1'b0;
    total += 2;
    if (got != 9) begin bad++; $display("FAIL flush_count: got %0d want 9", got); end
    if (popped_cnt !== 4'd9) begin bad++; $display("FAIL flush_cnt: got %0d want 9", popped_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w[3];
    int got;
    got = 0;
    do_reset();
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 6; i++) wr_q.push_back(16'hC000 + 16'(i));
    for (int c = 0; c < 10 && got < 1; c++) begin
      @(negedge clk); #1;
      if (m_valid && m_ready) got++;
    end
    total++;
    if (got != 1) begin bad++; $display("FAIL rstmid_timeout: got %0d want 1", got); end
    #2;
    rst_n = 1'b0;
    #1;
    total += 4;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", m_valid); end
    if (popped_cnt !== '0) begin bad++; $display("FAIL rstmid_cnt: got %0d want 0", popped_cnt); end
    if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL rstmid_rd_en: got %b want 0", fifo_rd_en); end
    if (m_data !== '0) begin bad++; $display("FAIL rstmid_data: got %h want 0", m_data); end
    wr_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got = 0;
    for (int i = 0; i < 3; i++) begin w[i] = 16'($urandom); wr_q.push_back(w[i]); end
    for (int c = 0; c < 15; c++) begin
      @(negedge clk); #1;
      if (m_valid && m_ready) begin
        total++;
        if (got >= 3) begin bad++; $display("FAIL rstmid_extra: got %h want none", m_data); end
        else if (m_data !== w[got]) begin
          bad++; $display("FAIL rstmid_data2: got %h want %h", m_data, w[got]);
        end
        got++;
      end
    end
    total += 2;
    if (got != 3) begin bad++; $display("FAIL rstmid_count: got %0d want 3", got); end
    if (popped_cnt !== 4'd3) begin bad++; $display("FAIL rstmid_cnt2: got %0d want 3", popped_cnt); end
  endtask

  task automatic test_wrap_underflow();
    int got;
    got = 0;
    do_reset();
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 17; i++) wr_q.push_back(16'(i));
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (m_valid && m_ready) got++;
    end
    total += 2;
    if (got != 17) begin bad++; $display("FAIL wrap_count: got %0d want 17", got); end
    if (popped_cnt !== 4'd1) begin bad++; $display("FAIL wrap_cnt: got %0d want 1", popped_cnt); end
    // Underflow with no read outstanding is not ours.
    @(negedge clk); uf_force = 1'b1;
    @(negedge clk); uf_force = 1'b0; #1;
    total++;
    if (underflow_err !== 1'b0) begin bad++; $display("FAIL uf_idle: got %b want 0", underflow_err); end
    wr_q.push_back(16'h5A5A);
    @(negedge clk); #1;
    total++;
    if (fifo_rd_en !== 1'b1) begin bad++; $display("FAIL uf_rd_issue: got %b want 1", fifo_rd_en); end
    @(negedge clk); uf_force = 1'b1;
    @(negedge clk); uf_force = 1'b0; #1;
    total++;
    if (underflow_err !== 1'b1) begin bad++; $display("FAIL uf_set: got %b want 1", underflow_err); end
    repeat (5) @(negedge clk);
    #1;
    total++;
    if (underflow_err !== 1'b1) begin bad++; $display("FAIL uf_sticky: got %b want 1", underflow_err); end
    do_reset();
    #1;
    total++;
    if (underflow_err !== 1'b0) begin bad++; $display("FAIL uf_clear: got %b want 0", underflow_err); end
  endtask

  task automatic test_random();
    logic [DW-1:0] src[$];
    logic [DW-1:0] exp[$];
    logic [DW-1:0] w;
    int n, k;
    do_reset();
    n = $urandom_range(30, 50);
    for (int i = 0; i < n; i++) begin w = 16'($urandom); src.push_back(w); exp.push_back(w); end
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (c < 300) begin
        m_ready = ($urandom_range(0, 3) != 0);
        enable  = ($urandom_range(0, 9) != 0);
      end else begin
        m_ready = 1'b1;
        enable  = 1'b1;
      end
      if (src.size() > 0 && $urandom_range(0, 2) == 0) begin
        k = $urandom_range(1, 3);
        for (int j = 0; j < k && src.size() > 0; j++) wr_q.push_back(src.pop_front());
      end
      #1;
      total++;
      if (fifo_underflow !== 1'b0) begin bad++; $display("FAIL rand_fifo_uf: got %b want 0", fifo_underflow); end
      if (m_valid && m_ready) begin
        total++;
        if (exp.size() == 0) begin bad++; $display("FAIL rand_extra: got %h want none", m_data); end
        else begin
          w = exp.pop_front();
          if (m_data !== w) begin bad++; $display("FAIL rand_data: got %h want %h", m_data, w); end
        end
      end
    end
    total += 3;
    if (exp.size() != 0) begin bad++; $display("FAIL rand_left: got %0d left want 0", exp.size()); end
    if (popped_cnt !== 4'(n)) begin bad++; $display("FAIL rand_cnt: got %0d want %0d", popped_cnt, n % 16); end
    if (underflow_err !== 1'b0) begin bad++; $display("FAIL rand_uf_err: got %b want 0", underflow_err); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_single();
    test_flush();
    test_reset_mid();
    test_wrap_underflow();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
